pixel_scanout: RTL and testbench
================================

# pixel_scanout

Display-side end of the pixel-plot interface. Accepts `plot`/`x`/`y`/`colour` writes from the drawing FSMs into a 160×120×3-bit framebuffer and reads that framebuffer back out as 640×480@60 VGA, with each stored pixel replicated 4×4. After reset it clears the whole framebuffer to black before accepting writes. It sits between the top-level drawing logic and the board VGA pins.

## Interface
- `CLK_DIV`, 2: clock cycles per VGA pixel; 50 MHz gives a 25 MHz pixel rate.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.
- `clock` in 1: the only clock; all logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `plot` in 1: write strobe; one pixel is written per cycle it is high.
- `x` in 8: write column, 0..159.
- `y` in 7: write row, 0..119.
- `colour` in 3: `{R,G,B}`; `3'b100` is red.
- `clear_busy` out 1: high while the post-reset clear sweep runs; writes are ignored while it is high.
- `vga_r`, `vga_g`, `vga_b` out 8 each: colour channels.
- `vga_hs`, `vga_vs` out 1 each: syncs, active-low.
- `vga_blank_n` out 1: high only in the visible region.
- `vga_pix_en` out 1: one-cycle pulse per pixel, for the DAC clock.
- `frame_start` out 1: one-cycle pulse when scanout reaches hcount=0, vcount=0.

## Operation
- **Control FSM**
  - Two states, CLEAR and RUN. Reset enters CLEAR with `clr_addr`=0.
  - CLEAR writes 0 to `clr_addr` each cycle and increments it.
  - At `clr_addr`=19199 it performs the last write, then moves to RUN on the next edge. CLEAR lasts exactly 19200 cycles.
  - `clear_busy` = (state==CLEAR).
- **Writes (RUN only)**
  - A write happens when `plot`=1, `x`<160 and `y`<120.
  - Address = y*160+x, computed as (y<<7)+(y<<5)+x in 15 bits.
  - The write commits on the same rising edge.
  - Out-of-range coordinates are silently dropped.
  - Inputs are not held across cycles; the caller repeats the strobe if needed.
- **Scanout counters**
  - The divider produces `pix_tick` every `CLK_DIV` clocks.
  - `hcount` runs 0..799 and advances on `pix_tick`.
  - On `hcount` wrap, `vcount` advances 0..524 and wraps to 0.
  - Counters run in both CLEAR and RUN.
- **Read path**
  - Read address = (vcount>>2)*160 + (hcount>>2), valid only when visible.
  - Visible = `hcount`<640 && `vcount`<480.
- **Sync generation**
  - `vga_hs` = 0 for `hcount` in 656..751.
  - `vga_vs` = 0 for `vcount` in 490..491.
- **Colour expansion**
  - Each `colour` bit drives its channel to 8'hFF when 1, 8'h00 when 0.
  - RGB is forced to 0 when not visible or when in CLEAR.
  - `vga_blank_n` is 0 throughout CLEAR.
- **Simultaneous read/write** to the same address: the read returns the old data.
- **Reset mid-frame**: counters return to 0, the FSM re-enters CLEAR, and the framebuffer is cleared again.

## Timing
- Reset values:
  - Counters, `clr_addr`, divider: 0.
  - `vga_r/g/b`: 0.
  - `vga_hs`, `vga_vs`: 1.
  - `vga_blank_n`, `vga_pix_en`, `frame_start`: 0.
  - `clear_busy`: 1 on the first cycle after reset release.
- Framebuffer read latency is 1 clock; the colour, blank and sync outputs are registered once more.
  - `vga_hs`, `vga_vs` and `vga_blank_n` go through the same 2-clock delay, so every pin reflects the counter state from 2 clocks earlier.
  - `vga_pix_en` and `frame_start` are delayed identically.
- A write at edge N is visible to a scanout read at edge N+1 or later.
- Frame period = 800×525×`CLK_DIV` clocks, which is 840000 at `CLK_DIV`=2.
- `frame_start` pulses once per frame.

## Structure
- Shared package holds:
  - `FB_W`=160, `FB_H`=120, `FB_DEPTH`=19200, `SCALE_SHIFT`=2.
  - VGA timing defaults.
  - Colour constants BLACK=3'b000, RED=3'b100.
- Sub-module `vga_timing`: divider, `hcount`/`vcount`, raw hs/vs/visible, `pix_tick`, `frame_start`.
- The framebuffer is inferred simple-dual-port RAM inside `pixel_scanout`: one write port, one registered read port.

## Test plan
- Reset for 3 cycles, then release:
  - Every output holds its reset value while `reset_n`=0.
  - `clear_busy` stays high for exactly 19200 cycles, then falls.
- After the clear, preload RAM with garbage via backdoor and reset again → every visible pixel of the next frame is rgb 0.
- Write (0,0) = 3'b100 and (159,119) = 3'b011:
  - Screen pixels (0..3, 0..3) show r=FF, g=00, b=00.
  - Screen pixels (636..639, 476..479) show r=00, g=FF, b=FF.
  - All other pixels are 0.
- Write x=160 and y=120 with `colour`=3'b111 → no RAM location changes; check by full-frame compare.
- Measure the syncs:
  - `vga_hs` is low for 96 pixel ticks starting 656 ticks after `hcount`=0.
  - `vga_vs` is low for 2 lines.
  - `frame_start` pulses are 840000 clocks apart.
- Assert `reset_n`=0 for 1 cycle at `vcount`=200 → counters restart at 0, `clear_busy` rises, and the next full frame is black.

Source files
------------

// File: rtl/pixel_scanout_pkg.sv
// Shared constants, state type and helpers for the pixel scanout block.
package pixel_scanout_pkg;

   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int FB_DEPTH    = 19200;
   localparam int SCALE_SHIFT = 2;

   // 640x480@60 defaults; the divider turns 50 MHz into the 25 MHz pixel rate
   localparam int DEF_CLK_DIV = 2;
   localparam int DEF_H_VIS   = 640;
   localparam int DEF_H_FP    = 16;
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_V_VIS   = 480;
   localparam int DEF_V_FP    = 10;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } ctrl_state_t;

   // row*160 + col without a multiplier: 160 = 128 + 32
   function automatic logic [14:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
      logic [14:0] row_w;
      row_w = {8'd0, row};
      return (row_w << 7) + (row_w << 5) + {7'd0, col};
   endfunction

   // One colour bit drives a whole 8-bit channel
   function automatic logic [7:0] expand_bit(input logic b);
      return b ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/pixel_scanout_vga_timing.sv
// Pixel divider, raster counters and raw (undelayed) sync/visible decode.
module vga_timing
   import pixel_scanout_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP
)(
   input  logic       clock,
   input  logic       reset_n,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       pix_tick,
   output logic       visible,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       frame_start
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic [3:0] div_r;
   logic [9:0] h_r;
   logic [9:0] v_r;

   // Clock divider: wraps after CLK_DIV clocks, the last clock of each pixel is the tick
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         div_r <= 4'd0;
      end else if (pix_tick) begin
         div_r <= 4'd0;
      end else begin
         div_r <= div_r + 4'd1;
      end
   end

   // Raster counters: hcount on every pixel tick, vcount on hcount wrap
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         h_r <= 10'd0;
         v_r <= 10'd0;
      end else if (pix_tick) begin
         if (h_r == H_LAST) begin
            h_r <= 10'd0;
            v_r <= (v_r == V_LAST) ? 10'd0 : v_r + 10'd1;
         end else begin
            h_r <= h_r + 10'd1;
         end
      end
   end

   // Raw decode of the current counter state
   always_comb begin
      pix_tick    = (div_r == DIV_LAST);
      visible     = (h_r < H_VIS_W) && (v_r < V_VIS_W);
      hsync_n     = !((h_r >= HS_FIRST) && (h_r <= HS_LAST));
      vsync_n     = !((v_r >= VS_FIRST) && (v_r <= VS_LAST));
      frame_start = (h_r == 10'd0) && (v_r == 10'd0) && (div_r == 4'd0);
      hcount      = h_r;
      vcount      = v_r;
   end

endmodule

// File: rtl/pixel_scanout.sv
// 160x120x3 framebuffer with post-reset clear, plot write port and 4x-scaled VGA scanout.
module pixel_scanout
   import pixel_scanout_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       plot,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   output logic       clear_busy,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_pix_en,
   output logic       frame_start
);

   localparam logic [14:0] CLR_LAST = 15'(FB_DEPTH - 1);

   ctrl_state_t state_r, state_next_s;
   logic [14:0] clr_addr_r, clr_addr_next_s;
   logic        we_s;
   logic [14:0] wr_addr_s;
   logic [2:0]  wr_data_s;
   logic [14:0] rd_addr_s;
   logic [2:0]  rd_data_r;
   logic [2:0]  fb [FB_DEPTH];

   logic [9:0]  hcount_s, vcount_s;
   logic        tick_s, visible_s, hs_s, vs_s, fs_s;
   logic        show_r, hs_d_r, vs_d_r, tick_d_r, fs_d_r;

   vga_timing #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clock(clock), .reset_n(reset_n), .hcount(hcount_s), .vcount(vcount_s),
      .pix_tick(tick_s), .visible(visible_s), .hsync_n(hs_s), .vsync_n(vs_s),
      .frame_start(fs_s)
   );

   assign clear_busy = (state_r == ST_CLEAR);

   // Control state register: reset restarts the clear sweep from address 0
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r    <= ST_CLEAR;
         clr_addr_r <= 15'd0;
      end else begin
         state_r    <= state_next_s;
         clr_addr_r <= clr_addr_next_s;
      end
   end

   // Next state and write-port source: the clear sweep owns the port until it finishes
   always_comb begin
      state_next_s    = state_r;
      clr_addr_next_s = clr_addr_r;
      we_s            = 1'b0;
      wr_addr_s       = fb_addr(x, y);
      wr_data_s       = colour;
      case (state_r)
         ST_CLEAR: begin
            we_s      = 1'b1;
            wr_addr_s = clr_addr_r;
            wr_data_s = BLACK;
            if (clr_addr_r == CLR_LAST) begin
               state_next_s    = ST_RUN;
               clr_addr_next_s = 15'd0;
            end else begin
               clr_addr_next_s = clr_addr_r + 15'd1;
            end
         end
         ST_RUN: begin
            we_s = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
         end
         default: begin
            state_next_s    = ST_CLEAR;
            clr_addr_next_s = 15'd0;
         end
      endcase
   end

   // Framebuffer write port
   always_ff @(posedge clock) begin
      if (reset_n && we_s) begin
         fb[wr_addr_s] <= wr_data_s;
      end
   end

   // Scanout read address: each stored pixel covers a 4x4 block of the screen
   always_comb begin
      rd_addr_s = 15'd0;
      if (visible_s) begin
         rd_addr_s = fb_addr(8'(hcount_s >> SCALE_SHIFT), 7'(vcount_s >> SCALE_SHIFT));
      end else begin
         rd_addr_s = 15'd0;
      end
   end

   // Framebuffer read port; a same-edge write is not seen (old data returned)
   always_ff @(posedge clock) begin
      rd_data_r <= fb[rd_addr_s];
   end

   // First delay stage keeps timing strobes aligned with the RAM read
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         show_r   <= 1'b0;
         hs_d_r   <= 1'b1;
         vs_d_r   <= 1'b1;
         tick_d_r <= 1'b0;
         fs_d_r   <= 1'b0;
      end else begin
         show_r   <= visible_s && (state_r == ST_RUN);
         hs_d_r   <= hs_s;
         vs_d_r   <= vs_s;
         tick_d_r <= tick_s;
         fs_d_r   <= fs_s;
      end
   end

   // Output registers: colour expansion with blanking outside the visible area and during clear
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         vga_r       <= 8'h00;
         vga_g       <= 8'h00;
         vga_b       <= 8'h00;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_pix_en  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= show_r ? expand_bit(rd_data_r[2]) : 8'h00;
         vga_g       <= show_r ? expand_bit(rd_data_r[1]) : 8'h00;
         vga_b       <= show_r ? expand_bit(rd_data_r[0]) : 8'h00;
         vga_hs      <= hs_d_r;
         vga_vs      <= vs_d_r;
         vga_blank_n <= show_r;
         vga_pix_en  <= tick_d_r;
         frame_start <= fs_d_r;
      end
   end

endmodule

// File: tb/tb_pixel_scanout.sv
// Self-checking bench for pixel_scanout: every cycle is compared against a raster model
// derived from the cycle count since reset, with a reduced raster so frames are short.
module tb_pixel_scanout;

   localparam int CD = 2;
   localparam int HV = 32, HF = 4, HSY = 8, HB = 4;
   localparam int VV = 24, VF = 2, VSY = 2, VB = 2;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;
   localparam int FRAME = HT * VT * CD;
   localparam int DEPTH = 19200;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       plot = 1'b0;
   logic [7:0] x = 8'd0;
   logic [6:0] y = 7'd0;
   logic [2:0] colour = 3'd0;
   logic       clear_busy, vga_hs, vga_vs, vga_blank_n, vga_pix_en, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;

   pixel_scanout #(
      .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
   ) dut (
      .clock(clock), .reset_n(reset_n), .plot(plot), .x(x), .y(y), .colour(colour),
      .clear_busy(clear_busy), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_pix_en(vga_pix_en), .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // clock edges since the last reset edge
   int kc = 0;
   always @(posedge clock) begin
      if (!reset_n) kc <= 0;
      else kc <= kc + 1;
   end

   typedef struct {
      int         k;
      int         addr;
      logic [2:0] col;
   } wr_t;

   logic [2:0] mem [DEPTH];
   wr_t        pend [$];
   int         vectors = 0;
   int         miscompares = 0;

   // a write issued at state K lands in RAM at edge K+1; screen at state k shows RAM read at edge k-1
   task automatic retire(input int upto);
      wr_t w;
      while (pend.size() > 0 && pend[0].k <= upto) begin
         w = pend.pop_front();
         mem[w.addr] = w.col;
      end
   endtask

   task automatic check_cycle();
      int j, p, h, v, d;
      logic vis, run, ebsy, ehs, evs, ebl, epe, efs;
      logic [2:0] c;
      logic [29:0] exp_v, obs_v;
      retire(kc - 3);
      ebsy = (kc < DEPTH);
      c = 3'b000;
      if (kc < 2) begin
         ehs = 1'b1; evs = 1'b1; ebl = 1'b0; epe = 1'b0; efs = 1'b0;
      end else begin
         j = kc - 2;
         p = j / CD;
         d = j % CD;
         h = p % HT;
         v = (p / HT) % VT;
         vis = (h < HV) && (v < VV);
         run = (j >= DEPTH);
         ebl = vis && run;
         if (ebl) c = mem[(v / 4) * 160 + (h / 4)];
         ehs = !((h >= HV + HF) && (h < HV + HF + HSY));
         evs = !((v >= VV + VF) && (v < VV + VF + VSY));
         epe = (d == CD - 1);
         efs = (h == 0) && (v == 0) && (d == 0);
      end
      exp_v = {ebsy, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, ehs, evs, ebl, epe, efs};
      obs_v = {clear_busy, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_pix_en, frame_start};
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL scan k=%0d observed=%h expected=%h", kc, obs_v, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clock);
      check_cycle();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive_write(input logic [7:0] wx, input logic [6:0] wy, input logic [2:0] wc);
      wr_t w;
      plot = 1'b1; x = wx; y = wy; colour = wc;
      if (kc >= DEPTH && wx < 8'd160 && wy < 7'd120) begin
         w.k = kc; w.addr = int'(wy) * 160 + int'(wx); w.col = wc;
         pend.push_back(w);
      end
      step();
      plot = 1'b0;
   endtask

   task automatic ram_compare(input string tag);
      retire(kc);
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         assert (dut.fb[i] === mem[i]) else begin
            miscompares++;
            $error("FAIL %s addr=%0d observed=%0d expected=%0d", tag, i, dut.fb[i], mem[i]);
         end
      end
   endtask

   initial begin
      int  guard;
      logic reached;
      logic [7:0] rx;
      logic [6:0] ry;
      for (int i = 0; i < DEPTH; i++) mem[i] = 3'b000;

      // reset held for 3 cycles: all outputs at reset values
      reset_n = 1'b0;
      run_cycles(3);
      reset_n = 1'b1;

      // a write during the clear sweep must be ignored
      while (kc < 100) step();
      drive_write(8'd0, 7'd0, 3'b100);
      while (kc < DEPTH + 5) step();

      // directed corner pixels and out-of-range writes
      drive_write(8'd0, 7'd0, 3'b100);
      drive_write(8'd159, 7'd119, 3'b011);
      drive_write(8'd160, 7'd0, 3'b111);
      drive_write(8'd0, 7'd120, 3'b111);
      drive_write(8'd200, 7'd127, 3'b111);
      drive_write(8'd159, 7'd120, 3'b111);
      drive_write(8'd160, 7'd5, 3'b111);
      run_cycles(2 * FRAME);
      ram_compare("ram_directed");

      // random writes, mostly into the visible corner, some anywhere incl. out of range
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            rx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            ry = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            drive_write(rx, ry, 3'($urandom_range(0, 7)));
         end else begin
            step();
         end
      end
      run_cycles(FRAME);
      ram_compare("ram_random");

      // one-cycle reset while scanout is on line 12 of the frame
      reached = 1'b0;
      guard = 0;
      while (!reached && guard < FRAME + 4) begin
         if (((kc / CD) / HT) % VT == 12) reached = 1'b1;
         else step();
         guard++;
      end
      vectors++;
      assert (reached === 1'b1) else begin
         miscompares++;
         $error("FAIL wait_line12 observed=%0d expected=1", reached);
      end
      reset_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 3'b000;
      pend.delete();
      step();
      reset_n = 1'b1;
      while (kc < DEPTH + 2 * FRAME) step();
      ram_compare("ram_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
